// File: rtl/rtc_time_core.sv
// rtl/rtc_time_core.sv - calendar/time-of-day counter with checked load path (option macro: RTC_WDAY_EN)
module rtc_time_core #(
  parameter int CLK_HZ   = 50000000,
  parameter int RST_YEAR = 2000,
  parameter int YEAR_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_year,
  input  logic [7:0]  load_month,
  input  logic [7:0]  load_day,
  input  logic [7:0]  load_hour,
  input  logic [7:0]  load_minute,
  input  logic [7:0]  load_sec,
  input  logic [2:0]  load_wday,
  output logic        load_ack,
  output logic        load_err,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  sec,
  output logic [2:0]  wday,
  output logic        tick_1hz
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic {ST_RUN, ST_CHECK} state_t;

  state_t        state_q;
  logic          ready_q, ack_q, err_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   year_q, year_d, hyear_q;
  logic [7:0]    month_q, month_d, hmonth_q;
  logic [7:0]    day_q, day_d, hday_q;
  logic [7:0]    hour_q, hour_d, hhour_q;
  logic [7:0]    min_q, min_d, hmin_q;
  logic [7:0]    sec_q, sec_d, hsec_q;
  logic          tick;
  logic          load_ok;
  logic          commit;

  function automatic logic is_leap(input logic [15:0] y);
    return (y[1:0] == 2'b00) && (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
  endfunction

  function automatic logic [7:0] days_in_month(input logic [15:0] y, input logic [7:0] m);
    case (m)
      8'd2:                     days_in_month = is_leap(y) ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11:  days_in_month = 8'd30;
      default:                  days_in_month = 8'd31;
    endcase
  endfunction

`ifdef RTC_WDAY_EN
  logic [2:0] wday_q, wday_d, hwday_q;
  logic       wday_ok;
  assign wday_ok = (hwday_q <= 3'd6);
  assign wday    = wday_q;
`else
  logic       unused_wday;
  logic       wday_ok;
  assign unused_wday = ^load_wday;
  assign wday_ok     = 1'b1;
  assign wday        = 3'd0;
`endif

  assign tick = run_en && (presc_q == PW'(CLK_HZ - 1));

  // Range check of the held request; only meaningful while in CHECK
  assign load_ok = (hmonth_q >= 8'd1) && (hmonth_q <= 8'd12) &&
                   (hday_q >= 8'd1) && (hday_q <= days_in_month(hyear_q, hmonth_q)) &&
                   (hhour_q <= 8'd23) && (hmin_q <= 8'd59) && (hsec_q <= 8'd59) &&
                   (hyear_q <= 16'(YEAR_MAX)) && wday_ok;

  assign commit = (state_q == ST_CHECK) && load_ok;

  // Next time: a commit overrides a coincident tick, otherwise the tick cascades
  always_comb begin
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
`ifdef RTC_WDAY_EN
    wday_d  = wday_q;
`endif
    presc_d = presc_q;
    if (commit) begin
      year_d  = hyear_q;
      month_d = hmonth_q;
      day_d   = hday_q;
      hour_d  = hhour_q;
      min_d   = hmin_q;
      sec_d   = hsec_q;
`ifdef RTC_WDAY_EN
      wday_d  = hwday_q;
`endif
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (sec_q != 8'd59) begin
        sec_d = sec_q + 8'd1;
      end else begin
        sec_d = 8'd0;
        if (min_q != 8'd59) begin
          min_d = min_q + 8'd1;
        end else begin
          min_d = 8'd0;
          if (hour_q != 8'd23) begin
            hour_d = hour_q + 8'd1;
          end else begin
            hour_d = 8'd0;
`ifdef RTC_WDAY_EN
            wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
`endif
            if (day_q != days_in_month(year_q, month_q)) begin
              day_d = day_q + 8'd1;
            end else begin
              day_d = 8'd1;
              if (month_q != 8'd12) begin
                month_d = month_q + 8'd1;
              end else begin
                month_d = 8'd1;
                year_d  = (year_q == 16'(YEAR_MAX)) ? 16'd0 : year_q + 16'd1;
              end
            end
          end
        end
      end
    end else if (run_en) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Time and prescaler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      year_q  <= 16'(RST_YEAR);
      month_q <= 8'd1;
      day_q   <= 8'd1;
      hour_q  <= 8'd0;
      min_q   <= 8'd0;
      sec_q   <= 8'd0;
`ifdef RTC_WDAY_EN
      wday_q  <= 3'd6;
`endif
      presc_q <= '0;
    end else begin
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
`ifdef RTC_WDAY_EN
      wday_q  <= wday_d;
`endif
      presc_q <= presc_d;
    end
  end

  // Load FSM: capture in RUN, judge for one cycle in CHECK, pulse ack/err after
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      ready_q  <= 1'b1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      hyear_q  <= '0;
      hmonth_q <= '0;
      hday_q   <= '0;
      hhour_q  <= '0;
      hmin_q   <= '0;
      hsec_q   <= '0;
`ifdef RTC_WDAY_EN
      hwday_q  <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (load_valid && ready_q) begin
            hyear_q  <= load_year;
            hmonth_q <= load_month;
            hday_q   <= load_day;
            hhour_q  <= load_hour;
            hmin_q   <= load_minute;
            hsec_q   <= load_sec;
`ifdef RTC_WDAY_EN
            hwday_q  <= load_wday;
`endif
            state_q  <= ST_CHECK;
            ready_q  <= 1'b0;
          end
        end
        ST_CHECK: begin
          ack_q   <= load_ok;
          err_q   <= !load_ok;
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = ready_q;
  assign load_ack   = ack_q;
  assign load_err   = err_q;
  assign year       = year_q;
  assign month      = month_q;
  assign day        = day_q;
  assign hour       = hour_q;
  assign minute     = min_q;
  assign sec        = sec_q;
  assign tick_1hz   = tick;

endmodule

// File: tb/tb_rtc_time_core.sv
// tb/tb_rtc_time_core.sv - self-checking bench for rtc_time_core with calendar reference model
module tb_rtc_time_core;

  localparam int CLK_HZ = 10;
`ifdef RTC_WDAY_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef struct {
    int y; int mo; int d; int h; int mi; int s; int wd;
  } tm_t;

  logic        clk = 1'b0;
  logic        rst, run_en, load_valid;
  logic        load_ready, load_ack, load_err, tick_1hz;
  logic [15:0] load_year, year;
  logic [7:0]  load_month, load_day, load_hour, load_minute, load_sec;
  logic [7:0]  month, day, hour, minute, sec;
  logic [2:0]  load_wday, wday;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  rtc_time_core #(.CLK_HZ(CLK_HZ), .RST_YEAR(2000), .YEAR_MAX(9999)) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_year(load_year), .load_month(load_month), .load_day(load_day),
    .load_hour(load_hour), .load_minute(load_minute), .load_sec(load_sec),
    .load_wday(load_wday), .load_ack(load_ack), .load_err(load_err),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .sec(sec), .wday(wday), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit leap(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dim(input int y, input int m);
    if (m == 2) return leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic bit valid_time(input tm_t t);
    return (t.mo >= 1) && (t.mo <= 12) && (t.d >= 1) && (t.d <= dim(t.y, t.mo)) &&
           (t.h <= 23) && (t.mi <= 59) && (t.s <= 59) && (t.y <= 9999) &&
           (!WD_EN || t.wd <= 6);
  endfunction

  // Advance by one second using seconds-of-day arithmetic
  function automatic tm_t next_sec(input tm_t t);
    tm_t r = t;
    int sod = t.h * 3600 + t.mi * 60 + t.s + 1;
    if (sod == 86400) begin
      sod  = 0;
      r.wd = (t.wd + 1) % 7;
      r.d  = t.d + 1;
      if (r.d > dim(t.y, t.mo)) begin
        r.d  = 1;
        r.mo = t.mo + 1;
        if (r.mo > 12) begin
          r.mo = 1;
          r.y  = (t.y + 1) % 10000;
        end
      end
    end
    r.h  = sod / 3600;
    r.mi = (sod / 60) % 60;
    r.s  = sod % 60;
    return r;
  endfunction

  function automatic tm_t mk(input int y, mo, d, h, mi, s, wd);
    tm_t t;
    t.y = y; t.mo = mo; t.d = d; t.h = h; t.mi = mi; t.s = s; t.wd = wd;
    return t;
  endfunction

  // Reference model, stepped on every rising edge from the driven inputs
  tm_t mt, mhold;
  int  mpresc;
  bit  mchk, mack, merr, mvalid = 1'b0;

  always @(posedge clk) begin
    bit mtick, commit;
    if (rst) begin
      mt = mk(2000, 1, 1, 0, 0, 0, 6);
      mpresc = 0; mchk = 0; mack = 0; merr = 0; mvalid = 1;
    end else if (mvalid) begin
      mtick  = run_en && (mpresc == CLK_HZ - 1);
      commit = 0;
      mack = 0; merr = 0;
      if (mchk) begin
        commit = valid_time(mhold);
        mack = commit; merr = !commit; mchk = 0;
      end else if (load_valid) begin
        mhold = mk(int'(load_year), int'(load_month), int'(load_day), int'(load_hour),
                   int'(load_minute), int'(load_sec), int'(load_wday));
        mchk = 1;
      end
      if (commit) begin
        mt = mhold; mpresc = 0;
      end else if (mtick) begin
        mt = next_sec(mt); mpresc = 0;
      end else if (run_en) begin
        mpresc++;
      end
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    if (mvalid) begin
      chk("ready", int'(load_ready), int'(!mchk));
      chk("ack", int'(load_ack), int'(mack));
      chk("err", int'(load_err), int'(merr));
      chk("tick", int'(tick_1hz), int'(run_en && mpresc == CLK_HZ - 1));
      chk("year", int'(year), mt.y);
      chk("month", int'(month), mt.mo);
      chk("day", int'(day), mt.d);
      chk("hour", int'(hour), mt.h);
      chk("minute", int'(minute), mt.mi);
      chk("sec", int'(sec), mt.s);
      chk("wday", int'(wday), WD_EN ? mt.wd : 0);
    end
  end

  task automatic drive(input tm_t t);
    load_year = 16'(t.y); load_month = 8'(t.mo); load_day = 8'(t.d);
    load_hour = 8'(t.h); load_minute = 8'(t.mi); load_sec = 8'(t.s); load_wday = 3'(t.wd);
  endtask

  task automatic wait_tick(input string nm);
    bit seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (tick_1hz) seen = 1;
    end
    chk(nm, int'(seen), 1);
  endtask

  task automatic load_req(input tm_t t, output bit ack, output bit err);
    drive(t);
    load_valid = 1'b1;
    @(posedge clk); #1;
    chk("ready_in_check", int'(load_ready), 0);
    #1 load_valid = 1'b0;
    @(posedge clk); #1;
    ack = load_ack; err = load_err;
    #1;
  endtask

  task automatic chk_time(input string nm, input tm_t t);
    chk({nm, ".y"}, int'(year), t.y);
    chk({nm, ".mo"}, int'(month), t.mo);
    chk({nm, ".d"}, int'(day), t.d);
    chk({nm, ".h"}, int'(hour), t.h);
    chk({nm, ".mi"}, int'(minute), t.mi);
    chk({nm, ".s"}, int'(sec), t.s);
  endtask

  initial begin
    bit a, e;
    int t1, t2, nt, hold_cnt;
    tm_t r;
    rst = 1; run_en = 0; load_valid = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk_time("reset", mk(2000, 1, 1, 0, 0, 0, 6));
    chk("reset.wday", int'(wday), WD_EN ? 6 : 0);
    chk("reset.ready", int'(load_ready), 1);
    #1 rst = 0; run_en = 1;

    // Tick period and first second
    wait_tick("tick1"); t1 = cyc;
    @(posedge clk); #1 chk("first_sec", int'(sec), 1);
    wait_tick("tick2"); t2 = cyc;
    chk("tick_period", t2 - t1, 10);
    @(posedge clk); #2;

    // Year rollover
    load_req(mk(2023, 12, 31, 23, 59, 59, 0), a, e);
    chk("ack_2023", int'(a), 1);
    wait_tick("tick_2023");
    @(posedge clk); #1;
    chk_time("ny2024", mk(2024, 1, 1, 0, 0, 0, 0));
    chk("ny2024.wday", int'(wday), WD_EN ? 1 : 0);
    #1;

    // Leap-day handling
    load_req(mk(2024, 2, 28, 23, 59, 59, 3), a, e);
    chk("ack_leap", int'(a), 1);
    wait_tick("tick_leap1");
    @(posedge clk); #1 chk_time("leap1", mk(2024, 2, 29, 0, 0, 0, 0));
    wait_tick("tick_leap2");
    @(posedge clk); #1 chk_time("leap2", mk(2024, 2, 29, 0, 0, 1, 0));
    #1;
    load_req(mk(2100, 2, 28, 23, 59, 59, 0), a, e);
    chk("ack_2100", int'(a), 1);
    wait_tick("tick_2100");
    @(posedge clk); #1 chk_time("y2100", mk(2100, 3, 1, 0, 0, 0, 0));
    #1;
    load_req(mk(2000, 2, 29, 0, 0, 0, 2), a, e);
    chk("ack_2000_0229", int'(a), 1);

    // Rejected loads
    load_req(mk(2023, 2, 29, 0, 0, 0, 0), a, e);
    chk("err_2023_0229", int'(e), 1);
    chk("noack_2023_0229", int'(a), 0);
    load_req(mk(2023, 13, 1, 0, 0, 0, 0), a, e);
    chk("err_month13", int'(e), 1);
    load_req(mk(2023, 5, 1, 24, 0, 0, 0), a, e);
    chk("err_hour24", int'(e), 1);

    // Commit coinciding with a tick
    wait_tick("tick_align");
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2;
    drive(mk(2030, 6, 15, 12, 34, 56, 5));
    load_valid = 1'b1;
    @(posedge clk); #1;
    chk("coinc_tick", int'(tick_1hz), 1);
    t1 = cyc;
    #1 load_valid = 1'b0;
    @(posedge clk); #1;
    chk("coinc_ack", int'(load_ack), 1);
    chk_time("coinc", mk(2030, 6, 15, 12, 34, 56, 5));
    wait_tick("tick_after_coinc");
    chk("coinc_period", cyc - t1, 10);
    @(posedge clk); #2;

    // Frozen time and the YEAR_MAX wrap
    run_en = 0; nt = 0;
    repeat (25) begin
      @(negedge clk);
      if (tick_1hz) nt++;
    end
    chk("frozen_ticks", nt, 0);
    @(posedge clk); #2;
    load_req(mk(9999, 12, 31, 23, 59, 59, 4), a, e);
    chk("ack_9999", int'(a), 1);
    repeat (15) @(posedge clk);
    #1 chk_time("frozen_load", mk(9999, 12, 31, 23, 59, 59, 0));
    #1 run_en = 1;
    wait_tick("tick_9999");
    @(posedge clk); #1 chk_time("wrap0", mk(0, 1, 1, 0, 0, 0, 0));
    #1;

    // Reset during CHECK aborts the load
    drive(mk(2011, 3, 3, 3, 3, 3, 3));
    load_valid = 1'b1;
    @(posedge clk); #2;
    load_valid = 1'b0; rst = 1;
    @(posedge clk); #1;
    chk("rst_chk_ack", int'(load_ack), 0);
    chk("rst_chk_err", int'(load_err), 0);
    chk_time("rst_chk", mk(2000, 1, 1, 0, 0, 0, 0));
    #1 rst = 0;
    @(posedge clk); #1;
    chk("rst_chk_ack2", int'(load_ack), 0);
    chk("rst_chk_err2", int'(load_err), 0);
    #1;

    // Randomized traffic checked by the model
    hold_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      run_en = ($urandom_range(0, 15) != 0);
      rst    = ($urandom_range(0, 599) == 0);
      if (hold_cnt > 0) begin
        hold_cnt--;
      end else begin
        load_valid = ($urandom_range(0, 7) == 0);
        if (load_valid) begin
          r.y  = ($urandom_range(0, 3) == 0) ? 9999 : int'($urandom_range(0, 10001));
          r.mo = $urandom_range(0, 13);
          r.wd = $urandom_range(0, 7);
          if ($urandom_range(0, 1) == 0) begin
            r.mo = $urandom_range(1, 12);
            r.d = dim(r.y, r.mo); r.h = 23; r.mi = 59; r.s = $urandom_range(55, 59);
          end else begin
            r.d  = $urandom_range(0, 32);
            r.h  = $urandom_range(0, 24);
            r.mi = $urandom_range(0, 60);
            r.s  = $urandom_range(0, 60);
          end
          drive(r);
          hold_cnt = $urandom_range(0, 2);
        end
      end
      @(posedge clk); #2;
    end
    rst = 0; load_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_time_core.md
Name: rtc_time_core

Overview:
- Free-running calendar/time-of-day counter. It is the consumer of the time-setting path.
- Accepts a complete date/time over a valid/ready load interface, range-checks it, and either commits it or rejects it.
- Advances seconds through years at 1 Hz derived from clk.
- Feeds the display and the set-mode logic with the live year/month/day/hour/minute/sec values.

Parameters:
- CLK_HZ, 50000000, clk cycles per second; prescaler terminal count is CLK_HZ-1.
- RST_YEAR, 2000, year loaded on reset.
- YEAR_MAX, 9999, last valid year; the year after it wraps to 0.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous reset, active-high
- run_en  input  1  1 = time advances; 0 = prescaler and time frozen
- load_valid  input  1  load request; fields are stable while high
- load_ready  output  1  block can accept a load this cycle
- load_year  input  16  binary year
- load_month  input  8  binary month, 1..12
- load_day  input  8  binary day, 1..days_in_month
- load_hour  input  8  0..23
- load_minute  input  8  0..59
- load_sec  input  8  0..59
- load_wday  input  3  day of week, 0=Sunday (used only with option)
- load_ack  output  1  one-cycle pulse: load committed
- load_err  output  1  one-cycle pulse: load rejected
- year  output  16 / month, day, hour, minute, sec  output  8 each  current time, binary
- wday  output  3  day of week
- tick_1hz  output  1  one-cycle pulse on each second boundary

Behaviour:
- Reset (rst=1 at posedge), all outputs take these values:
  - year=RST_YEAR, month=1, day=1, hour=0, minute=0, sec=0, wday=6 (Saturday).
  - Prescaler=0, state=RUN, load_ready=1, load_ack=0, load_err=0, tick_1hz=0.
  - Reset mid-CHECK aborts the load; no ack or err is produced.
- Prescaler:
  - Counts 0..CLK_HZ-1 while run_en=1 in RUN; holds its value when run_en=0.
  - tick_1hz=1 in the cycle the prescaler equals CLK_HZ-1 and run_en=1; the prescaler returns to 0 on the next edge.
  - Time fields update on the same edge (the cascade below resolves in one edge).
- Cascade on tick:
  - sec 59->0 carries to minute; minute 59->0 carries to hour; hour 23->0 carries to day.
  - day==days_in_month -> 1 and carries to month; month 12->1 carries to year; year YEAR_MAX->0.
- Days in month:
  - 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11.
  - Feb: 29 if leap, else 28. Leap = (year%4==0) and (year%100!=0 or year%400==0).
- State machine, two states:
  - RUN: load_ready=1. On load_valid && load_ready, capture all load_* fields into holding registers, go to CHECK.
  - CHECK (exactly 1 cycle): load_ready=0.
    - Valid when month 1..12, day 1..days_in_month(load_year, load_month), hour<=23, minute<=59, sec<=59, year<=YEAR_MAX, and (option on) wday<=6.
    - If valid: commit all fields, clear prescaler to 0, pulse load_ack.
    - Else: time unchanged, pulse load_err.
    - Return to RUN.
- Load latency: accept edge + 1 cycle; ack/err are asserted in the cycle after CHECK.
- Time keeping during CHECK:
  - Time keeps advancing while in CHECK.
  - If a tick coincides with a successful commit, the commit wins and the tick increment is discarded (tick_1hz still pulses).
  - A rejected load never loses a tick.
- run_en=0 does not block loads. A committed load while frozen stays frozen at the loaded value.
- load_valid held high after acceptance is not re-accepted until CHECK ends. If it is still high in RUN, it is treated as a new request.

Optional Feature:
- Macro: RTC_WDAY_EN.
- Defined:
  - wday increments modulo 7 on every day carry.
  - load_wday is captured and validated (<=6); wday is loaded on commit.
- Undefined:
  - wday tied to 0.
  - load_wday ignored and excluded from validation.
  - No weekday registers exist.

Test Plan:
- Reset with CLK_HZ=10 -> outputs 2000-01-01 00:00:00, wday=6; tick_1hz every 10 clk with run_en=1; sec 0->1 on first tick.
- Load 2023-12-31 23:59:59, run one tick -> ack 2 cycles after accept; then 2024-01-01 00:00:00; wday +1 mod 7 with option.
- Load 2024-02-28 23:59:59, 2 ticks -> 02-29 00:00:00 then 00:00:01. Load 2100-02-28 23:59:59, 1 tick -> 2100-03-01. Load 2000-02-29 -> ack.
- Load 2023-02-29 00:00:00, then month=13, then hour=24 -> load_err pulse each; time keeps counting; load_ready=0 only in CHECK cycles.
- Load committed in the same cycle as a tick -> time equals the loaded value exactly, prescaler=0; next tick after 10 clk.
- run_en=0 for 25 clk -> no tick_1hz, time frozen; load 9999-12-31 23:59:59 -> ack; run_en=1, one tick -> 0000-01-01 00:00:00; rst asserted during CHECK -> no ack/err, reset values.
